// File: rtl/nios_oci_dct_pkg.sv
// Shared definitions for the OCI data-compression-trace (DCT) sequencer.
//
// Contents:
//   ENTRY_W / MAX_ENTRIES / DROP_W : packing and counter geometry
//   BUF_W / CNT_W / FRM_W          : derived buffer, count and frame widths
//   FRM_*                          : bit offsets of the fields inside a frame
//   dct_state_e                    : sequencer states
//   insert_entry / make_frame      : packing helpers used by the top level
package nios_oci_dct_pkg;

  localparam int ENTRY_W     = 2;
  localparam int MAX_ENTRIES = 15;
  localparam int DROP_W      = 8;
  localparam int CNT_W       = 4;
  localparam int BUF_W       = ENTRY_W * MAX_ENTRIES;
  localparam int FRM_W       = 1 + CNT_W + BUF_W;

  // Frame layout: {flush_flag, count[3:0], buffer[29:0]}
  localparam int FRM_BUF_LSB   = 0;
  localparam int FRM_CNT_LSB   = BUF_W;
  localparam int FRM_FLUSH_BIT = BUF_W + CNT_W;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(MAX_ENTRIES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } dct_state_e;

  // Write a code into slot idx (LSB-first). A constant-indexed loop keeps
  // every part-select in range, even for idx values that never occur.
  function automatic logic [BUF_W-1:0] insert_entry(
    input logic [BUF_W-1:0]   buffer,
    input logic [CNT_W-1:0]   idx,
    input logic [ENTRY_W-1:0] code
  );
    logic [BUF_W-1:0] result;
    result = buffer;
    for (int i = 0; i < MAX_ENTRIES; i++) begin
      if (idx == CNT_W'(i)) begin
        result[i*ENTRY_W +: ENTRY_W] = code;
      end
    end
    return result;
  endfunction

  function automatic logic [FRM_W-1:0] make_frame(
    input logic             flush_flag,
    input logic [CNT_W-1:0] count,
    input logic [BUF_W-1:0] buffer
  );
    logic [FRM_W-1:0] frame;
    frame                            = '0;
    frame[FRM_FLUSH_BIT]             = flush_flag;
    frame[FRM_CNT_LSB +: CNT_W]      = count;
    frame[FRM_BUF_LSB +: BUF_W]      = buffer;
    return frame;
  endfunction

endpackage

// File: rtl/nios_oci_dct_frame_reg.sv
// Single-entry valid/ready output register for DCT frames.
//
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   load        : commit load_data this edge (only asserted while free=1)
//   load_data   : frame to commit
//   frm_ready   : downstream trace FIFO accepts the held frame
//   frm_valid   : a frame is held
//   frm_data    : the held frame, stable while frm_valid && !frm_ready
//   free        : register can take a new frame on this edge
module nios_oci_dct_frame_reg
  import nios_oci_dct_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [FRM_W-1:0] load_data,
  input  logic             frm_ready,
  output logic             frm_valid,
  output logic [FRM_W-1:0] frm_data,
  output logic             free
);

  // A frame leaving on this edge frees the slot for a same-edge refill.
  assign free = !frm_valid || frm_ready;

  // Load has priority over drain so a back-to-back commit has no bubble.
  // Data is only written on load, which keeps it stable while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frm_valid <= 1'b0;
      frm_data  <= '0;
    end else if (load) begin
      frm_valid <= 1'b1;
      frm_data  <= load_data;
    end else if (frm_ready) begin
      frm_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/nios_system_nios2_oci_dct_sequencer.sv
// OCI DCT sequencer: packs 2-bit branch codes into a 30-bit buffer of up to
// 15 entries and commits each full or flushed buffer as one 35-bit frame.
//
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   trace_enable  : tracing on; a falling edge forces a flush
//   br_valid      : branch code present
//   br_code       : branch code, 2'b00 ignored
//   flush_req     : single-cycle flush pulse
//   frm_ready     : trace FIFO accepts a frame
//   frm_valid     : frame held in the output register
//   frm_data      : {flush_flag, count, buffer}
//   dct_buffer    : live packing buffer
//   dct_count     : live entry count (0..15)
//   overflow      : sticky, an entry was dropped
//   drop_cnt      : saturating count of dropped entries
//   idle          : in IDLE with no frame pending
module nios_system_nios2_oci_dct_sequencer
  import nios_oci_dct_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               trace_enable,
  input  logic               br_valid,
  input  logic [ENTRY_W-1:0] br_code,
  input  logic               flush_req,
  input  logic               frm_ready,
  output logic               frm_valid,
  output logic [FRM_W-1:0]   frm_data,
  output logic [BUF_W-1:0]   dct_buffer,
  output logic [CNT_W-1:0]   dct_count,
  output logic               overflow,
  output logic [DROP_W-1:0]  drop_cnt,
  output logic               idle
);

  dct_state_e       state, state_n;
  logic [BUF_W-1:0] buf_n, buf_a;
  logic [CNT_W-1:0] count_n, count_a;
  logic             flush_pend, pend_n;
  logic             te_q;
  logic             te_fall;
  logic             code_ok;
  logic             flush;
  logic             load;
  logic [FRM_W-1:0] load_data;
  logic             drop;
  logic             free;

  nios_oci_dct_frame_reg u_frame_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (load_data),
    .frm_ready (frm_ready),
    .frm_valid (frm_valid),
    .frm_data  (frm_data),
    .free      (free)
  );

  assign code_ok = br_valid && (br_code != '0);
  assign te_fall = te_q && !trace_enable;
  assign idle    = (state == IDLE) && !frm_valid;

  // Next-state logic. In FILL the incoming branch is appended first
  // (buf_a/count_a), then full/flush is evaluated on the appended result,
  // so the 15th entry and a same-cycle flush both land in the same frame.
  always_comb begin
    state_n   = state;
    buf_n     = dct_buffer;
    count_n   = dct_count;
    pend_n    = flush_pend;
    load      = 1'b0;
    load_data = '0;
    drop      = 1'b0;
    flush     = flush_req || te_fall;
    buf_a     = code_ok ? insert_entry(dct_buffer, dct_count, br_code) : dct_buffer;
    count_a   = dct_count + CNT_W'(code_ok);

    case (state)
      IDLE: begin
        pend_n = 1'b0;
        if (trace_enable) begin
          state_n = FILL;
        end
      end

      FILL: begin
        if ((count_a == FULL_COUNT) || (flush && (count_a != '0))) begin
          if (free) begin
            load      = 1'b1;
            load_data = make_frame(flush, count_a, buf_a);
            buf_n     = '0;
            count_n   = '0;
            state_n   = te_fall ? IDLE : FILL;
          end else begin
            buf_n   = buf_a;
            count_n = count_a;
            pend_n  = flush;
            state_n = HOLD;
          end
        end else begin
          buf_n   = buf_a;
          count_n = count_a;
          if (te_fall) begin
            state_n = IDLE;
          end
        end
      end

      HOLD: begin
        // Buffer is frozen; anything arriving now is lost.
        drop   = code_ok;
        pend_n = flush_pend || flush;
        if (free) begin
          load      = 1'b1;
          load_data = make_frame(pend_n, dct_count, dct_buffer);
          buf_n     = '0;
          count_n   = '0;
          pend_n    = 1'b0;
          state_n   = trace_enable ? FILL : IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Sequencer state, packing buffer and trace-enable history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dct_buffer <= '0;
      dct_count  <= '0;
      flush_pend <= 1'b0;
      te_q       <= 1'b0;
    end else begin
      state      <= state_n;
      dct_buffer <= buf_n;
      dct_count  <= count_n;
      flush_pend <= pend_n;
      te_q       <= trace_enable;
    end
  end

  // Drop bookkeeping; cleared only by reset, counter saturates at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_nios_system_nios2_oci_dct_sequencer.sv
// Self-checking bench for nios_system_nios2_oci_dct_sequencer. Expected
// frames are queued when the stimulus that should produce them is driven
// and compared when the DUT hands a frame to the trace FIFO.
module tb_nios_system_nios2_oci_dct_sequencer;

  logic        clk;
  logic        reset;
  logic        trace_enable;
  logic        br_valid;
  logic [1:0]  br_code;
  logic        flush_req;
  logic        frm_ready;
  logic        frm_valid;
  logic [34:0] frm_data;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        idle;

  int errorCount = 0;
  int checkCount = 0;
  logic [34:0] expQ[$];

  nios_system_nios2_oci_dct_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .trace_enable (trace_enable),
    .br_valid     (br_valid),
    .br_code      (br_code),
    .flush_req    (flush_req),
    .frm_ready    (frm_ready),
    .frm_valid    (frm_valid),
    .frm_data     (frm_data),
    .dct_buffer   (dct_buffer),
    .dct_count    (dct_count),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
    .idle         (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checkCount++;
    if (got !== want) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [34:0] expFrame(input logic flag, input logic [3:0] cnt, input logic [29:0] bufv);
    return {flag, cnt, bufv};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of branch/flush inputs, then drop the pulses.
  task automatic applyStimulus(input logic bv, input logic [1:0] code, input logic fl);
    br_valid  = bv;
    br_code   = code;
    flush_req = fl;
    step();
    br_valid  = 1'b0;
    br_code   = 2'b00;
    flush_req = 1'b0;
  endtask

  // Frame monitor: a frame with valid&&ready at the negedge is taken by
  // the FIFO on the next posedge, so each frame is seen exactly once here.
  always @(negedge clk) begin
    if (!reset && frm_valid && frm_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("exp_frame_available", 64'(expQ.size()), 64'd1);
      end else begin
        checkOutput("frame", 64'(frm_data), 64'(expQ.pop_front()));
      end
    end
  end

  // Watchdog against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    trace_enable = 1'b0;
    br_valid     = 1'b0;
    br_code      = 2'b00;
    flush_req    = 1'b0;
    frm_ready    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_frm_valid", 64'(frm_valid), 64'd0);
    checkOutput("rst_idle", 64'(idle), 64'd1);
    checkOutput("rst_count", 64'(dct_count), 64'd0);
    checkOutput("rst_drop", 64'(drop_cnt), 64'd0);
    reset = 1'b0;

    // Full buffer of code 01 commits on the 15th edge.
    $display("[TB] full buffer commit");
    trace_enable = 1'b1;
    step();
    expQ.push_back(expFrame(1'b0, 4'd15, 30'h15555555));
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 2'b01, 1'b0);
    checkOutput("pre_full_count", 64'(dct_count), 64'd14);
    checkOutput("pre_full_valid", 64'(frm_valid), 64'd0);
    applyStimulus(1'b1, 2'b01, 1'b0);
    checkOutput("full_valid", 64'(frm_valid), 64'd1);
    checkOutput("full_count", 64'(dct_count), 64'd0);

    // Three mixed codes then a flush.
    $display("[TB] flush of partial buffer");
    applyStimulus(1'b1, 2'b01, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b0);
    checkOutput("part_buffer", 64'(dct_buffer), 64'h39);
    checkOutput("part_count", 64'(dct_count), 64'd3);
    checkOutput("part_no_frame", 64'(frm_valid), 64'd0);
    expQ.push_back(expFrame(1'b1, 4'd3, 30'h39));
    applyStimulus(1'b0, 2'b00, 1'b1);
    checkOutput("flush_valid", 64'(frm_valid), 64'd1);
    step();
    checkOutput("flush_drained", 64'(frm_valid), 64'd0);

    // Back-pressure: second full buffer holds, later branches dropped.
    $display("[TB] hold and drop");
    frm_ready = 1'b0;
    expQ.push_back(expFrame(1'b0, 4'd15, 30'h15555555));
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 2'b01, 1'b0);
    expQ.push_back(expFrame(1'b0, 4'd15, 30'h3FFFFFFF));
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 2'b11, 1'b0);
    checkOutput("hold_count", 64'(dct_count), 64'd15);
    checkOutput("hold_buffer", 64'(dct_buffer), 64'h3FFFFFFF);
    checkOutput("hold_frame_stable", 64'(frm_data), 64'(expFrame(1'b0, 4'd15, 30'h15555555)));
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'b01, 1'b0);
    checkOutput("drop_cnt5", 64'(drop_cnt), 64'd5);
    checkOutput("overflow_set", 64'(overflow), 64'd1);
    checkOutput("hold_count_frozen", 64'(dct_count), 64'd15);
    frm_ready = 1'b1;
    step();
    checkOutput("release_valid", 64'(frm_valid), 64'd1);
    checkOutput("release_count", 64'(dct_count), 64'd0);
    applyStimulus(1'b1, 2'b10, 1'b0);
    checkOutput("back_in_fill", 64'(dct_count), 64'd1);

    // Trace disable with four entries flushes and idles.
    $display("[TB] trace disable flush");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b10, 1'b0);
    checkOutput("te_count", 64'(dct_count), 64'd4);
    checkOutput("te_buffer", 64'(dct_buffer), 64'hAA);
    expQ.push_back(expFrame(1'b1, 4'd4, 30'hAA));
    trace_enable = 1'b0;
    step();
    checkOutput("te_valid", 64'(frm_valid), 64'd1);
    checkOutput("te_idle_pending", 64'(idle), 64'd0);
    step();
    checkOutput("te_idle", 64'(idle), 64'd1);
    applyStimulus(1'b1, 2'b01, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b1);
    checkOutput("idle_ignore_count", 64'(dct_count), 64'd0);
    checkOutput("idle_no_frame", 64'(frm_valid), 64'd0);
    checkOutput("idle_no_drop", 64'(drop_cnt), 64'd5);

    // Branch plus flush at count 14 gives one 15-entry flush frame.
    $display("[TB] branch and flush together");
    trace_enable = 1'b1;
    step();
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 2'b01, 1'b0);
    checkOutput("bf_count14", 64'(dct_count), 64'd14);
    expQ.push_back(expFrame(1'b1, 4'd15, 30'h35555555));
    applyStimulus(1'b1, 2'b11, 1'b1);
    checkOutput("bf_valid", 64'(frm_valid), 64'd1);
    checkOutput("bf_count", 64'(dct_count), 64'd0);
    step();
    step();
    checkOutput("bf_single_frame", 64'(frm_valid), 64'd0);
    applyStimulus(1'b0, 2'b00, 1'b1);
    checkOutput("empty_flush_no_frame", 64'(frm_valid), 64'd0);
    applyStimulus(1'b1, 2'b00, 1'b0);
    checkOutput("reserved_code", 64'(dct_count), 64'd0);

    // Saturating drop counter, then async reset mid-HOLD.
    $display("[TB] saturation and reset in hold");
    frm_ready = 1'b0;
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 260; i++) applyStimulus(1'b1, 2'b10, 1'b0);
    checkOutput("drop_sat", 64'(drop_cnt), 64'd255);
    checkOutput("sat_hold_valid", 64'(frm_valid), 64'd1);
    checkOutput("sat_not_idle", 64'(idle), 64'd0);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("arst_valid", 64'(frm_valid), 64'd0);
    checkOutput("arst_data", 64'(frm_data), 64'd0);
    checkOutput("arst_buffer", 64'(dct_buffer), 64'd0);
    checkOutput("arst_count", 64'(dct_count), 64'd0);
    checkOutput("arst_overflow", 64'(overflow), 64'd0);
    checkOutput("arst_drop", 64'(drop_cnt), 64'd0);
    checkOutput("arst_idle", 64'(idle), 64'd1);
    #2;
    reset     = 1'b0;
    frm_ready = 1'b1;
    repeat (3) step();
    checkOutput("post_rst_no_frame", 64'(frm_valid), 64'd0);
    checkOutput("post_rst_count", 64'(dct_count), 64'd0);

    step();
    checkOutput("frames_outstanding", 64'(expQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
